// File: rtl/itoa_pkg.sv
// Shared types and constants for the integer-to-ASCII decimal converter.
package itoa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    EMIT_SIGN,
    EMIT_DIG,
    EMIT_TERM
  } itoa_state_t;

  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_MINUS = 8'h2D;
  localparam int          MAX_DIGITS  = 10;
  localparam logic [3:0]  INT_MIN_REM = 4'd8;
  localparam logic [31:0] INT_MIN_QUO = 32'd214748364;
  localparam logic [31:0] INT_MIN_VAL = 32'h8000_0000;

endpackage

// File: rtl/digit_stack.sv
// Small LIFO holding the decimal digits produced least-significant first.
module digit_stack
  import itoa_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] top,
  output logic       empty,
  output logic [3:0] count
);

  logic [3:0] mem [MAX_DIGITS];
  logic [3:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= 4'd0;
    end else if (push) begin
      count_reg <= count_reg + 4'd1;
    end else if (pop) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[count_reg] <= din;
    end
  end

  assign empty = (count_reg == 4'd0);
  assign count = count_reg;
  assign top   = empty ? 4'd0 : mem[count_reg - 4'd1];

endmodule

// File: rtl/div10.sv
// Combinational unsigned divide-by-ten: quotient and remainder in one cycle.
module div10 (
  input  logic [31:0] num,
  output logic [31:0] q,
  output logic [3:0]  r
);

  logic [63:0] prod;
  logic [3:0]  q_x10_low;
  logic        unused_prod_bits;

  // Reciprocal multiply: ceil(2^35/10) gives an exact floor(num/10) for any 32-bit num.
  assign prod      = {32'd0, num} * 64'h0000_0000_CCCC_CCCD;
  assign q         = {3'b000, prod[63:35]};
  assign q_x10_low = q[3:0] * 4'd10;
  assign r         = num[3:0] - q_x10_low;

  assign unused_prod_bits = ^prod[34:0];

endmodule

// File: rtl/itoa_ctrl.sv
// Signed 32-bit to ASCII decimal converter: divides one digit per cycle,
// then streams sign, digits (MSD first) and optional terminator.
module itoa_ctrl
  import itoa_pkg::*;
#(
  parameter bit         TERM_EN   = 1'b0,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  itoa_state_t state_reg, state_next;
  logic [31:0] mag_reg, mag_next;
  logic        neg_reg, neg_next;

  logic [31:0] div_q;
  logic [3:0]  div_r;
  logic        push, pop;
  logic [3:0]  push_digit;
  logic [3:0]  stack_top;
  logic        stack_empty;
  logic [3:0]  stack_count;

  div10 u_div10 (
    .num (mag_reg),
    .q   (div_q),
    .r   (div_r)
  );

  digit_stack u_stack (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (push_digit),
    .top   (stack_top),
    .empty (stack_empty),
    .count (stack_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      mag_reg   <= 32'd0;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mag_reg   <= mag_next;
      neg_reg   <= neg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mag_next   = mag_reg;
    neg_next   = neg_reg;
    push       = 1'b0;
    pop        = 1'b0;
    push_digit = 4'd0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          neg_next   = in_data[31];
          state_next = DIV;
          // INT_MIN has no positive 32-bit signed twin; peel its last digit here.
          if (in_data == INT_MIN_VAL) begin
            push       = 1'b1;
            push_digit = INT_MIN_REM;
            mag_next   = INT_MIN_QUO;
          end else begin
            mag_next = in_data[31] ? (~in_data + 32'd1) : in_data;
          end
        end
      end

      DIV: begin
        push       = 1'b1;
        push_digit = div_r;
        mag_next   = div_q;
        if (div_q == 32'd0) begin
          state_next = neg_reg ? EMIT_SIGN : EMIT_DIG;
        end
      end

      EMIT_SIGN: begin
        out_valid = 1'b1;
        out_data  = ASCII_MINUS;
        if (out_ready) begin
          state_next = EMIT_DIG;
        end
      end

      EMIT_DIG: begin
        out_valid = !stack_empty;
        out_data  = ASCII_ZERO + {4'd0, stack_top};
        out_last  = (stack_count == 4'd1) && !TERM_EN;
        if (out_ready && !stack_empty) begin
          pop = 1'b1;
          if (stack_count == 4'd1) begin
            state_next = TERM_EN ? EMIT_TERM : IDLE;
          end
        end
      end

      EMIT_TERM: begin
        out_valid = 1'b1;
        out_data  = TERM_CHAR;
        out_last  = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_itoa_ctrl.sv
// Randomized self-checking bench for itoa_ctrl against a string-level reference model.
module tb_itoa_ctrl;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0] in_data;
  logic [7:0]  out_data;
  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_last, t_busy;
  logic [31:0] t_in_data;
  logic [7:0]  t_out_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  itoa_ctrl #(.TERM_EN(1'b0), .TERM_CHAR(8'h0A)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  itoa_ctrl #(.TERM_EN(1'b1), .TERM_CHAR(8'h0A)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .out_last(t_out_last), .busy(t_busy)
  );

  // Reference: decimal string by plain arithmetic, plus expected accept-to-first-byte cycles.
  function automatic void model(input logic [31:0] v, input bit term, output bq_t s, output int lat);
    longint sv, mag;
    int nd;
    sv  = longint'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    s   = {};
    nd  = 0;
    do begin
      s.push_front(8'(48 + (mag % 10)));
      mag = mag / 10;
      nd++;
    end while (mag != 0);
    if (sv < 0) s.push_front(8'h2D);
    if (term) s.push_back(8'h0A);
    lat = (v == 32'h8000_0000) ? nd : nd + 1;
  endfunction

  function automatic string fmt(input bq_t q);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Drives one conversion and records what the sink saw; sel picks the terminator instance.
  task automatic collect(input bit sel, input logic [31:0] val, input bit stall,
                         output bq_t got, output int lat, output bit stable_ok,
                         output bit inrdy_ok, output bit rdy_after, output bit timeout);
    int c;
    bit done, pstall, v, l, ir, r;
    logic [7:0] d, pd;
    logic pl;
    got = {}; lat = -1; stable_ok = 1'b1; inrdy_ok = 1'b1; rdy_after = 1'b0; timeout = 1'b0;
    done = 1'b0; pstall = 1'b0; pd = 8'h00; pl = 1'b0;
    c = 0;
    @(negedge clk);
    while (!(sel ? t_in_ready : in_ready) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) begin
      timeout = 1'b1;
      return;
    end
    if (sel) begin t_in_valid = 1'b1; t_in_data = val; end
    else     begin in_valid   = 1'b1; in_data   = val; end
    @(negedge clk);
    in_valid = 1'b0; t_in_valid = 1'b0;
    in_data = $urandom; t_in_data = $urandom;
    c = 1;
    while (!done && c < 300) begin
      v  = sel ? t_out_valid : out_valid;
      d  = sel ? t_out_data  : out_data;
      l  = sel ? t_out_last  : out_last;
      ir = sel ? t_in_ready  : in_ready;
      if (ir) inrdy_ok = 1'b0;
      if (pstall && (!v || d !== pd || l !== pl)) stable_ok = 1'b0;
      if (v && lat < 0) lat = c;
      r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sel) t_out_ready = r; else out_ready = r;
      if (v && r) begin
        got.push_back(d);
        if (l) done = 1'b1;
      end
      pstall = v && !r;
      pd = d; pl = l;
      @(negedge clk);
      c++;
    end
    if (!done) timeout = 1'b1;
    rdy_after = sel ? t_in_ready : in_ready;
    out_ready = 1'b1; t_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rstn = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_directed();
    logic [31:0] vals [5];
    bq_t exp, got;
    int elat, lat;
    bit st, ir, ra, to;
    vals[0] = 32'd0; vals[1] = 32'd123; vals[2] = -32'sd45;
    vals[3] = 32'h8000_0000; vals[4] = 32'h7FFF_FFFF;
    foreach (vals[k]) begin
      model(vals[k], 1'b0, exp, elat);
      collect(1'b0, vals[k], 1'b0, got, lat, st, ir, ra, to);
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL directed_timeout in=%08h", vals[k]); end
      vectors++;
      if (got.size() != exp.size()) begin
        miscompares++;
        $display("FAIL directed_len in=%08h got=%0d [%s] exp=%0d [%s]", vals[k], got.size(), fmt(got), exp.size(), fmt(exp));
      end else begin
        foreach (exp[i]) begin
          vectors++;
          if (got[i] !== exp[i]) begin miscompares++; $display("FAIL directed_byte in=%08h idx=%0d got=%02h exp=%02h", vals[k], i, got[i], exp[i]); end
        end
      end
      vectors++; if (lat != elat) begin miscompares++; $display("FAIL directed_latency in=%08h got=%0d exp=%0d", vals[k], lat, elat); end
      vectors++; if (ir !== 1'b1) begin miscompares++; $display("FAIL directed_in_ready_busy in=%08h got=high exp=low", vals[k]); end
      vectors++; if (ra !== 1'b1) begin miscompares++; $display("FAIL directed_in_ready_after in=%08h got=%b exp=1", vals[k], ra); end
      $display("directed in=%08h bytes=[%s] latency=%0d", vals[k], fmt(got), lat);
    end
  endtask

  task automatic test_stall();
    bq_t exp, ref_run, got;
    int elat, lat;
    bit st, ir, ra, to;
    model(32'd987654321, 1'b0, exp, elat);
    collect(1'b0, 32'd987654321, 1'b0, ref_run, lat, st, ir, ra, to);
    collect(1'b0, 32'd987654321, 1'b1, got, lat, st, ir, ra, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL stall_timeout"); end
    vectors++;
    if (got.size() != ref_run.size() || got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL stall_len got=[%s] unstalled=[%s] exp=[%s]", fmt(got), fmt(ref_run), fmt(exp));
    end else begin
      foreach (exp[i]) begin
        vectors++;
        if (got[i] !== exp[i] || ref_run[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL stall_byte idx=%0d got=%02h unstalled=%02h exp=%02h", i, got[i], ref_run[i], exp[i]);
        end
      end
    end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL stall_stable got=changed exp=held"); end
    vectors++; if (ir !== 1'b1) begin miscompares++; $display("FAIL stall_in_ready got=high exp=low"); end
    $display("stall in=987654321 bytes=[%s]", fmt(got));
  endtask

  task automatic test_term();
    bq_t exp, got;
    int elat, lat;
    bit st, ir, ra, to;
    model(32'd7, 1'b1, exp, elat);
    collect(1'b1, 32'd7, 1'b0, got, lat, st, ir, ra, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL term_timeout"); end
    vectors++;
    if (got.size() != exp.size()) begin
      miscompares++; $display("FAIL term_len got=[%s] exp=[%s]", fmt(got), fmt(exp));
    end else begin
      foreach (exp[i]) begin
        vectors++;
        if (got[i] !== exp[i]) begin miscompares++; $display("FAIL term_byte idx=%0d got=%02h exp=%02h", i, got[i], exp[i]); end
      end
    end
    vectors++; if (lat != elat) begin miscompares++; $display("FAIL term_latency got=%0d exp=%0d", lat, elat); end
    $display("term in=7 bytes=[%s]", fmt(got));
  endtask

  task automatic test_back_to_back();
    bq_t exp, got;
    int elat, lat;
    bit st, ir, ra, to;
    logic [31:0] v;
    for (int n = 0; n < 3; n++) begin
      v = $urandom;
      model(v, 1'b0, exp, elat);
      collect(1'b0, v, 1'b0, got, lat, st, ir, ra, to);
      vectors++; if (ra !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got=%b exp=1", ra); end
      vectors++;
      if (got.size() != exp.size()) begin
        miscompares++; $display("FAIL b2b_len in=%08h got=[%s] exp=[%s]", v, fmt(got), fmt(exp));
      end else begin
        foreach (exp[i]) begin
          vectors++;
          if (got[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_byte in=%08h idx=%0d got=%02h exp=%02h", v, i, got[i], exp[i]); end
        end
      end
      $display("b2b in=%08h bytes=[%s]", v, fmt(got));
    end
  endtask

  task automatic test_random();
    bq_t exp, got;
    int elat, lat;
    bit st, ir, ra, to;
    logic [31:0] v;
    for (int n = 0; n < 24; n++) begin
      case (n % 3)
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        default: v = -$urandom_range(1, 99999);
      endcase
      model(v, 1'b0, exp, elat);
      collect(1'b0, v, 1'b1, got, lat, st, ir, ra, to);
      vectors++;
      if (to !== 1'b0 || got.size() != exp.size()) begin
        miscompares++; $display("FAIL random_len in=%08h got=[%s] exp=[%s]", v, fmt(got), fmt(exp));
      end else begin
        foreach (exp[i]) begin
          vectors++;
          if (got[i] !== exp[i]) begin miscompares++; $display("FAIL random_byte in=%08h idx=%0d got=%02h exp=%02h", v, i, got[i], exp[i]); end
        end
      end
      vectors++; if (lat != elat) begin miscompares++; $display("FAIL random_latency in=%08h got=%0d exp=%0d", v, lat, elat); end
      vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL random_stable in=%08h", v); end
      $display("random in=%08h bytes=[%s]", v, fmt(got));
    end
  endtask

  task automatic test_reset_mid();
    int hs, c;
    bit seen;
    bq_t got;
    int lat;
    bit st, ir, ra, to;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    hs = 0; c = 0;
    while (!(out_valid && hs == 2) && c < 100) begin
      if (out_valid) hs++;
      @(negedge clk);
      c++;
    end
    vectors++; if (c >= 100) begin miscompares++; $display("FAIL rstmid_third_byte_timeout"); end
    #2 rstn = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_out_data got=%02h exp=00", out_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray_bytes got=valid exp=quiet"); end
    collect(1'b0, 32'd5, 1'b0, got, lat, st, ir, ra, to);
    vectors++;
    if (to !== 1'b0 || got.size() != 1) begin
      miscompares++; $display("FAIL rstmid_after_len got=[%s] exp=[35]", fmt(got));
    end else begin
      vectors++; if (got[0] !== 8'h35) begin miscompares++; $display("FAIL rstmid_after_byte got=%02h exp=35", got[0]); end
    end
    $display("reset_mid: after-reset conversion of 5 bytes=[%s]", fmt(got));
  endtask

  initial begin
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_data = 32'd0; t_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_term();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
